seq_divider: RTL



---
 rtl/div_pkg.sv | 14 +
 rtl/full_adder.sv | 13 +
 rtl/subtractor_nbit.sv | 26 ++
 rtl/seq_divider.sv | 118 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing constants for seq_divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full-adder cell used by the ripple datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/subtractor_nbit.sv
// subtractor_nbit: ripple subtractor a - b as a + ~b + 1; borrow is the inverted carry-out.
module subtractor_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] c;

    assign c[0]   = 1'b1;
    assign borrow = ~c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (c[i]),
            .s  (diff[i]),
            .co (c[i+1])
        );
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock with start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands with truncating division.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, dvs;
    logic [WIDTH:0]   r_sh, diff, r_nxt;
    logic [WIDTH-1:0] q_nxt, q_res, r_res, a_mag, b_mag;
    logic             borrow, accept, unused_msb;

    // done is gated so a start in the done cycle is not taken
    assign accept = (state == IDLE) && start && !done;

    assign r_sh  = {r, q[WIDTH-1]};
    assign r_nxt = borrow ? r_sh : diff;
    assign q_nxt = {q[WIDTH-2:0], ~borrow};
    assign unused_msb = r_nxt[WIDTH];

    subtractor_nbit #(.N(WIDTH + 1)) u_sub (
        .a      (r_sh),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_res = neg_q ? -q_nxt : q_nxt;
    assign r_res = neg_r ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_res = q_nxt;
    assign r_res = r_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cnt         <= '0;
                    r           <= '0;
                    q           <= a_mag;
                    dvs         <= b_mag;
                    div_by_zero <= (divisor == '0);
                    if (divisor == '0) begin
                        state     <= FINISH;
                        quotient  <= '1;
                        remainder <= dividend;
                    end else begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    r   <= r_nxt[WIDTH-1:0];
                    q   <= q_nxt;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        quotient  <= q_res;
                        remainder <= r_res;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
